// File: rtl/imem_responder_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory responder.
//   fetch_resp_t : one fetch response (PC, instruction pair, flags)
//   IMEM_WORD_W  : instruction word width
//   idx_w_f()    : width of a word index for a given array depth (min 1)
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_WORD_W     = 32;
  localparam int IMEM_PC_W       = 32;
  localparam int IMEM_BYTE_OFF_W = 2;   // byte-offset bits below the word index

  typedef struct packed {
    logic [IMEM_PC_W-1:0]   pc;
    logic [IMEM_WORD_W-1:0] inst0;
    logic [IMEM_WORD_W-1:0] inst1;
    logic                   inst1_valid;
    logic                   fault;
  } fetch_resp_t;

  // Index width for an array of 'depth' entries; never narrower than one bit.
  function automatic int idx_w_f(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
// Fetch-request / fetch-response bundle between the fetch stage and the
// instruction-memory responder.
//   master : fetch/decode side (drives requests, pops responses)
//   slave  : responder side
// Signals: req_valid/req_ready/req_pc, resp_valid/resp_ready, resp_pc,
//          resp_inst0, resp_inst1, resp_inst1_valid, resp_fault.
// -----------------------------------------------------------------------------
interface imem_responder_if;
  import imem_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [IMEM_PC_W-1:0]   req_pc;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IMEM_PC_W-1:0]   resp_pc;
  logic [IMEM_WORD_W-1:0] resp_inst0;
  logic [IMEM_WORD_W-1:0] resp_inst1;
  logic                   resp_inst1_valid;
  logic                   resp_fault;

  modport master (
    output req_valid, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_pc, resp_inst0, resp_inst1,
           resp_inst1_valid, resp_fault
  );

  modport slave (
    input  req_valid, req_pc, resp_ready,
    output req_ready, resp_valid, resp_pc, resp_inst0, resp_inst1,
           resp_inst1_valid, resp_fault
  );

endinterface

// File: rtl/imem_responder_fetch_resp_fifo.sv
// -----------------------------------------------------------------------------
// fetch_resp_fifo
// Synchronous in-order FIFO of fetch_resp_t with a flush that empties it.
//   clk, reset   : clock, asynchronous active-high reset
//   flush_i      : drop all entries at the next edge (wins over push)
//   push_i       : write push_data_i (ignored when full)
//   pop_i        : drop head entry (ignored when empty)
//   head_o       : head entry, held stable until popped
//   count_o      : number of stored entries
// -----------------------------------------------------------------------------
module fetch_resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_resp_t      push_data_i,
  input  logic             pop_i,
  output fetch_resp_t      head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = idx_w_f(DEPTH);

  fetch_resp_t      store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  // Explicit wrap so non-trivial depths never index past the storage.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  assign push_ok_s = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok_s  = pop_i && (count_q != '0);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        store_q[k] <= '0;
      end
    end else if (push_ok_s && !flush_i) begin
      store_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = store_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction memory serving (PC, PC+4) instruction pairs to the fetch stage
// through a fixed-latency read pipeline and an in-order response queue.
//   clk, reset        : clock, asynchronous active-high reset
//   flush             : discard every in-flight and queued response
//   bus (slave)       : request handshake and head-of-queue response
//   wr_en/wr_addr/wr_data : word write port used to load the array
// Build option IMEM_FAULT_EN: when defined, misaligned or out-of-range PCs
// return a fault entry; otherwise the index wraps modulo the array depth.
// -----------------------------------------------------------------------------
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 4,
  localparam int IDX_W      = idx_w_f(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  imem_responder_if.slave        bus,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_addr,
  input  logic [IMEM_WORD_W-1:0] wr_data
);

  // Wide enough for stage count plus queue count without overflow.
  localparam int CNT_W = $clog2(QDEPTH) + 2;

  logic [IMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic             accept_s, push_s, pop_s, req_ready_s, resp_valid_s;
  logic [IDX_W-1:0] idx0_s, idx1_s;
  fetch_resp_t      rd_entry_s, push_data_s, head_s;
  logic [CNT_W-1:0] stage_cnt_s, fifo_cnt_s, outstanding_s;

  assign idx0_s = bus.req_pc[IDX_W+1:2];
  assign idx1_s = idx0_s + IDX_W'(1'b1);

  // Combinational array read for the request being accepted this cycle.
  always_comb begin
    rd_entry_s    = '0;
    rd_entry_s.pc = bus.req_pc;
`ifdef IMEM_FAULT_EN
    if ((bus.req_pc[1:0] != 2'b00) || (bus.req_pc[31:IDX_W+2] != '0)) begin
      rd_entry_s.fault = 1'b1;
    end else begin
      rd_entry_s.inst0 = mem_q[idx0_s];
      // Last word has no successor inside the array.
      if (idx0_s != IDX_W'(DEPTH_WORDS - 1)) begin
        rd_entry_s.inst1       = mem_q[idx1_s];
        rd_entry_s.inst1_valid = 1'b1;
      end else begin
        rd_entry_s.inst1       = '0;
        rd_entry_s.inst1_valid = 1'b0;
      end
    end
`else
    // Index taken modulo the depth; inst1 wraps to word 0.
    rd_entry_s.inst0       = mem_q[idx0_s];
    rd_entry_s.inst1       = mem_q[idx1_s];
    rd_entry_s.inst1_valid = 1'b1;
    rd_entry_s.fault       = 1'b0;
`endif
  end

`ifndef IMEM_FAULT_EN
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{bus.req_pc[1:0], bus.req_pc[31:IDX_W+2]};
`endif

  // Array write port; not reset so loaded contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Credit check counts stage slots and queue slots; a same-cycle pop is
  // deliberately not credited so the queue can never overflow.
  assign outstanding_s = stage_cnt_s + fifo_cnt_s;
  assign req_ready_s   = !flush && (outstanding_s < CNT_W'(QDEPTH));
  assign accept_s      = bus.req_valid && req_ready_s;

  generate
    if (LATENCY == 1) begin : g_no_stage
      assign push_s      = accept_s;
      assign push_data_s = rd_entry_s;
      assign stage_cnt_s = '0;
    end else begin : g_stage
      localparam int NS = LATENCY - 1;

      logic [NS-1:0] vld_q;
      fetch_resp_t   data_q [NS];

      // Read pipeline: valid bits cleared by flush, data simply shifts.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
          for (int k = 0; k < NS; k++) begin
            data_q[k] <= '0;
          end
        end else begin
          if (flush) begin
            vld_q <= '0;
          end else begin
            vld_q[0] <= accept_s;
            for (int k = 1; k < NS; k++) begin
              vld_q[k] <= vld_q[k-1];
            end
          end
          data_q[0] <= rd_entry_s;
          for (int k = 1; k < NS; k++) begin
            data_q[k] <= data_q[k-1];
          end
        end
      end

      // Number of occupied pipeline stages.
      always_comb begin
        stage_cnt_s = '0;
        for (int k = 0; k < NS; k++) begin
          stage_cnt_s = stage_cnt_s + CNT_W'(vld_q[k]);
        end
      end

      assign push_s      = vld_q[NS-1] && !flush;
      assign push_data_s = data_q[NS-1];
    end
  endgenerate

  fetch_resp_fifo #(
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (fifo_cnt_s)
  );

  assign resp_valid_s = (fifo_cnt_s != '0) && !flush;
  assign pop_s        = resp_valid_s && bus.resp_ready;

  assign bus.req_ready        = req_ready_s;
  assign bus.resp_valid       = resp_valid_s;
  assign bus.resp_pc          = head_s.pc;
  assign bus.resp_inst0       = head_s.inst0;
  assign bus.resp_inst1       = head_s.inst1;
  assign bus.resp_inst1_valid = head_s.inst1_valid;
  assign bus.resp_fault       = head_s.fault;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Directed stimulus with hand-computed expected responses; accepted requests
// push their expected response into a queue that a negedge monitor pops and
// compares whenever a response is popped from the DUT.
// -----------------------------------------------------------------------------
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int QD    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  imem_responder_if bus ();

  imem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .QDEPTH      (QD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  fetch_resp_t exp_q[$];
  fetch_resp_t got_r, exp_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: compare every popped response against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.resp_valid && bus.resp_ready) begin
      got_r.pc          = bus.resp_pc;
      got_r.inst0       = bus.resp_inst0;
      got_r.inst1       = bus.resp_inst1;
      got_r.inst1_valid = bus.resp_inst1_valid;
      got_r.fault       = bus.resp_fault;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got pc=0x%08h, expected no response", got_r.pc);
      end else begin
        exp_r = exp_q.pop_front();
        if (got_r !== exp_r) begin
          errors++;
          $display("FAIL resp: got pc=%h i0=%h i1=%h v=%b f=%b expected pc=%h i0=%h i1=%h v=%b f=%b",
                   got_r.pc, got_r.inst0, got_r.inst1, got_r.inst1_valid, got_r.fault,
                   exp_r.pc, exp_r.inst0, exp_r.inst1, exp_r.inst1_valid, exp_r.fault);
        end
      end
    end
  end

  // All stimulus tasks start and end at posedge + 1.
  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                       input logic v, input logic f);
    fetch_resp_t e;
    int n;
    e.pc = pc; e.inst0 = i0; e.inst1 = i1; e.inst1_valid = v; e.fault = f;
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pc=0x%08h got not accepted expected accepted", pc);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Single request into an empty queue with consumer ready: checks latency.
  task automatic fetch_timed(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                             input logic v, input logic f);
    issue(pc, i0, i1, v, f);
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      chk1("lat_early_valid", bus.resp_valid, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("lat_valid", bus.resp_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_addr = 10'd0; wr_data = 32'd0;
    bus.req_valid = 1'b0; bus.req_pc = 32'd0; bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_resp_pc", bus.resp_pc, 32'd0);
    chk("rst_resp_inst0", bus.resp_inst0, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    wr(10'd0, 32'h11);   wr(10'd1, 32'h22); wr(10'd2, 32'h33); wr(10'd3, 32'h44);
    wr(10'd4, 32'h55);   wr(10'd5, 32'hAA); wr(10'd6, 32'h66);
    wr(10'd1023, 32'hDEAD0001);

    // Basic fetch and latency.
    fetch_timed(32'h0, 32'h11, 32'h22, 1'b1, 1'b0);

    // Back-to-back with consumer stalled: credit exhausts, head stable.
    bus.resp_ready = 1'b0;
    issue(32'h0, 32'h11, 32'h22, 1'b1, 1'b0);
    issue(32'h4, 32'h22, 32'h33, 1'b1, 1'b0);
    issue(32'h8, 32'h33, 32'h44, 1'b1, 1'b0);
    issue(32'hC, 32'h44, 32'h55, 1'b1, 1'b0);
    @(negedge clk);
    chk1("full_req_ready", bus.req_ready, 1'b0);
    chk1("full_resp_valid", bus.resp_valid, 1'b1);
    chk("head_pc", bus.resp_pc, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("head_pc_stable", bus.resp_pc, 32'h0);
    chk("head_inst0_stable", bus.resp_inst0, 32'h11);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    wait_drain();
    chk1("drained_req_ready", bus.req_ready, 1'b1);

    // Flush with responses queued and in flight.
    bus.resp_ready = 1'b0;
    issue(32'h0, 32'h11, 32'h22, 1'b1, 1'b0);
    issue(32'h4, 32'h22, 32'h33, 1'b1, 1'b0);
    issue(32'h8, 32'h33, 32'h44, 1'b1, 1'b0);
    flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_pc = 32'h10;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk1("flush_resp_valid", bus.resp_valid, 1'b0);
    chk1("flush_req_ready", bus.req_ready, 1'b0);
    #1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("post_flush_idle", bus.resp_valid, 1'b0);
      @(posedge clk); #1;
    end
    fetch_timed(32'h8, 32'h33, 32'h44, 1'b1, 1'b0);
    @(negedge clk);
    chk1("post_flush_alone", bus.resp_valid, 1'b0);
    @(posedge clk); #1;

    // Write in the accept cycle returns old data; the next read sees new data.
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hBB;
    issue(32'h14, 32'hAA, 32'h66, 1'b1, 1'b0);
    wr_en = 1'b0;
    wait_drain();
    fetch_timed(32'h14, 32'hBB, 32'h66, 1'b1, 1'b0);

    // Boundary / fault behaviour.
`ifdef IMEM_FAULT_EN
    fetch_timed(32'h1002, 32'h0, 32'h0, 1'b0, 1'b1);
    fetch_timed(32'h6, 32'h0, 32'h0, 1'b0, 1'b1);
    fetch_timed(32'hFFC, 32'hDEAD0001, 32'h0, 1'b0, 1'b0);
`else
    fetch_timed(32'h1002, 32'h11, 32'h22, 1'b1, 1'b0);
    fetch_timed(32'hFFC, 32'hDEAD0001, 32'h11, 1'b1, 1'b0);
`endif

    // Asynchronous reset with three responses outstanding.
    bus.resp_ready = 1'b0;
    issue(32'h0, 32'h11, 32'h22, 1'b1, 1'b0);
    issue(32'h4, 32'h22, 32'h33, 1'b1, 1'b0);
    issue(32'h8, 32'h33, 32'h44, 1'b1, 1'b0);
    @(negedge clk);
    chk1("pre_reset_valid", bus.resp_valid, 1'b1);
    chk1("pre_reset_req_ready", bus.req_ready, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("async_rst_resp_valid", bus.resp_valid, 1'b0);
    chk1("async_rst_req_ready", bus.req_ready, 1'b1);
    chk("async_rst_resp_pc", bus.resp_pc, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    fetch_timed(32'h0, 32'h11, 32'h22, 1'b1, 1'b0);

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
